// File: rtl/cpu_ce_gen.sv
// CPU clock-enable generator: fixed-rate enables plus a speed-level
// controlled CPU enable pair with a glitch-free level-switch sequence.
module cpu_ce_gen #(
   parameter int unsigned CNT_W         = 6,
   parameter int unsigned LEVELS        = CNT_W - 1,
   parameter int unsigned HOLD_TICKS    = 3,
   parameter int unsigned RAM_WAIT_LVL  = 3,
   parameter int unsigned TAPE_WAIT_LVL = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [2:0] level_req,
   input  logic       ram_ready,
   input  logic       tape_active,
   input  logic       ce_sp,
   input  logic       ce_sn,
   output logic       ce_cpu_p,
   output logic       ce_cpu_n,
   output logic       ce_cpu,
   output logic       ce_28m,
   output logic       ce_7mp,
   output logic       ce_7mn,
   output logic       ce_psg,
   output logic       cpu_en,
   output logic [2:0] level,
   output logic       level_ack
);

   localparam int unsigned LVL_W  = 3;
   localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(LEVELS - 1);
   localparam logic [LVL_W-1:0]  RAM_LVL   = LVL_W'(RAM_WAIT_LVL);
   localparam logic [LVL_W-1:0]  TAPE_LVL  = LVL_W'(TAPE_WAIT_LVL);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      RESUME = 2'd2
   } state_t;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  mask_c;
   logic [CNT_W-1:0]  top_c;
   logic              tp_c;
   logic              tn_c;
   logic              p_src_c;
   logic              n_src_c;
   logic [LVL_W-1:0]  lvl_sat_c;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              pend_q, pend_d;
   logic              en_d;
   logic [LVL_W-1:0]  lvl_d;
   logic              ack_d;

   // Free-running phase counter
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt + CNT_W'(1);
   end

   // Phase ticks for the current level and p/n source selection
   always_comb begin
      mask_c    = {CNT_W{1'b1}} >> (4'(level) + 4'd1);
      top_c     = (mask_c >> 1) + CNT_W'(mask_c != '0);
      tp_c      = (cnt & mask_c) == '0;
      tn_c      = (cnt & mask_c) == top_c;
      p_src_c   = (level == '0) ? ce_sp : tp_c;
      n_src_c   = (level == '0) ? ce_sn : tn_c;
      lvl_sat_c = (level_req > LVL_MAX) ? LVL_MAX : level_req;
   end

   // Registered fixed-rate and gated CPU enables
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ce_28m   <= 1'b0;
         ce_7mp   <= 1'b0;
         ce_7mn   <= 1'b0;
         ce_psg   <= 1'b0;
         ce_cpu_p <= 1'b0;
         ce_cpu_n <= 1'b0;
         ce_cpu   <= 1'b0;
      end else begin
         ce_28m   <= cnt[1:0] == 2'd0;
         ce_7mp   <= cnt[3:0] == 4'd0;
         ce_7mn   <= cnt[3:0] == 4'd8;
         ce_psg   <= cnt == '0;
         ce_cpu_p <= cpu_en & p_src_c;
         ce_cpu_n <= cpu_en & n_src_c;
         ce_cpu   <= cpu_en & tp_c;
      end
   end

   // Level-switch / stall sequencing, evaluated only on selected n ticks
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pend_d  = pend_q;
      en_d    = cpu_en;
      lvl_d   = level;
      ack_d   = 1'b0;
      if (n_src_c) begin
         if (lvl_sat_c != level) begin
            lvl_d   = lvl_sat_c;
            en_d    = 1'b0;
            hold_d  = HOLD_LOAD;
            pend_d  = 1'b1;
            state_d = HOLD;
         end else begin
            case (state_q)
               HOLD: begin
                  if (hold_q <= HOLD_W'(1)) begin
                     hold_d  = '0;
                     state_d = RESUME;
                  end else begin
                     hold_d = hold_q - HOLD_W'(1);
                  end
               end
               RESUME: begin
                  if (ram_ready) begin
                     en_d    = 1'b1;
                     ack_d   = pend_q;
                     pend_d  = 1'b0;
                     state_d = RUN;
                  end
               end
               RUN: begin
                  if (!ram_ready &&
                      ((level >= RAM_LVL) || ((level >= TAPE_LVL) && tape_active))) begin
                     en_d    = 1'b0;
                     state_d = RESUME;
                  end
               end
               default: state_d = RUN;
            endcase
         end
      end
   end

   // Sequencer state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RUN;
         hold_q    <= '0;
         pend_q    <= 1'b0;
         cpu_en    <= 1'b1;
         level     <= '0;
         level_ack <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         pend_q    <= pend_d;
         cpu_en    <= en_d;
         level     <= lvl_d;
         level_ack <= ack_d;
      end
   end

endmodule

// File: tb/tb_cpu_ce_gen.sv
// Self-checking bench for cpu_ce_gen: directed scenarios plus random stimulus
// against a tick-counting behavioural model.
module tb_cpu_ce_gen;

   localparam int CNT_W = 6;
   localparam int LEVELS = 5;
   localparam int HOLD_TICKS = 3;
   localparam int RAM_WAIT_LVL = 3;
   localparam int TAPE_WAIT_LVL = 2;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [2:0] level_req;
   logic       ram_ready, tape_active, ce_sp, ce_sn;
   logic       ce_cpu_p, ce_cpu_n, ce_cpu, ce_28m, ce_7mp, ce_7mn, ce_psg;
   logic       cpu_en, level_ack;
   logic [2:0] level;

   int checks = 0;
   int failures = 0;

   // model state
   int m_cnt, m_lvl, m_block;
   bit m_en, m_pend, m_n_last;
   bit e_p, e_n, e_cpu, e_28m, e_7mp, e_7mn, e_psg, e_en, e_ack;
   int e_lvl;

   // scenario observers
   int ack_cnt, low_ticks;
   bit saw_low;

   cpu_ce_gen dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .level_req(level_req),
      .ram_ready(ram_ready), .tape_active(tape_active), .ce_sp(ce_sp), .ce_sn(ce_sn),
      .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n), .ce_cpu(ce_cpu), .ce_28m(ce_28m),
      .ce_7mp(ce_7mp), .ce_7mn(ce_7mn), .ce_psg(ce_psg), .cpu_en(cpu_en),
      .level(level), .level_ack(level_ack)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_lvl = 0; m_block = 0; m_en = 1; m_pend = 0; m_n_last = 0;
      e_p = 0; e_n = 0; e_cpu = 0; e_28m = 0; e_7mp = 0; e_7mn = 0; e_psg = 0;
      e_en = 1; e_lvl = 0; e_ack = 0;
   endtask

   // One clock edge of the model, from current model state and driven inputs
   task automatic model_edge();
      int period, sat;
      bit tp, tn, p, n;
      if (!reset_n) begin
         model_reset();
         return;
      end
      period = 1 << (CNT_W - 1 - m_lvl);
      tp = (m_cnt % period) == 0;
      tn = (m_cnt % period) == period / 2;
      p  = (m_lvl == 0) ? ce_sp : tp;
      n  = (m_lvl == 0) ? ce_sn : tn;
      e_28m = (m_cnt % 4) == 0;
      e_7mp = (m_cnt % 16) == 0;
      e_7mn = (m_cnt % 16) == 8;
      e_psg = m_cnt == 0;
      e_p   = m_en && p;
      e_n   = m_en && n;
      e_cpu = m_en && tp;
      e_ack = 0;
      m_n_last = n;
      if (n) begin
         sat = (int'(level_req) > LEVELS - 1) ? LEVELS - 1 : int'(level_req);
         if (sat != m_lvl) begin
            m_lvl = sat; m_en = 0; m_block = HOLD_TICKS - 1; m_pend = 1;
         end else if (!m_en) begin
            if (m_block > 0) m_block--;
            else if (ram_ready) begin
               m_en = 1; e_ack = m_pend; m_pend = 0;
            end
         end else if (!ram_ready &&
                      (m_lvl >= RAM_WAIT_LVL || (m_lvl >= TAPE_WAIT_LVL && tape_active))) begin
            m_en = 0;
         end
      end
      e_en = m_en;
      e_lvl = m_lvl;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
   endtask

   task automatic compare_all();
      chk("ce_cpu_p", ce_cpu_p, e_p);
      chk("ce_cpu_n", ce_cpu_n, e_n);
      chk("ce_cpu", ce_cpu, e_cpu);
      chk("ce_28m", ce_28m, e_28m);
      chk("ce_7mp", ce_7mp, e_7mp);
      chk("ce_7mn", ce_7mn, e_7mn);
      chk("ce_psg", ce_psg, e_psg);
      chk("cpu_en", cpu_en, e_en);
      chk("level", level, e_lvl);
      chk("level_ack", level_ack, e_ack);
   endtask

   // Inputs already driven at a negedge; advance one clock and compare
   task automatic cycle();
      bit en_before;
      en_before = cpu_en;
      model_edge();
      @(posedge clk_sys);
      @(negedge clk_sys);
      compare_all();
      if (level_ack) ack_cnt++;
      if (m_n_last && !en_before) low_ticks++;
      if (!cpu_en) saw_low = 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         ce_sp = ($urandom_range(0, 3) == 0);
         ce_sn = ($urandom_range(0, 3) == 0);
         cycle();
      end
   endtask

   task automatic reset_literals(input string tag);
      chk({tag, "_rst_ce_cpu_p"}, ce_cpu_p, 0);
      chk({tag, "_rst_ce_cpu_n"}, ce_cpu_n, 0);
      chk({tag, "_rst_ce_psg"}, ce_psg, 0);
      chk({tag, "_rst_ce_28m"}, ce_28m, 0);
      chk({tag, "_rst_cpu_en"}, cpu_en, 1);
      chk({tag, "_rst_level"}, level, 0);
      chk({tag, "_rst_level_ack"}, level_ack, 0);
   endtask

   initial begin
      bit prev_p;
      reset_n = 1; level_req = 3'd4; ram_ready = 1; tape_active = 0; ce_sp = 0; ce_sn = 0;
      model_reset();
      #2 reset_n = 0;
      @(negedge clk_sys);
      reset_literals("init");
      run(3);

      // release: first cycle registers cnt==0
      reset_n = 1; ce_sp = 0; ce_sn = 0;
      cycle();
      chk("first_ce_psg", ce_psg, 1);
      chk("first_ce_28m", ce_28m, 1);

      // level 4 from reset
      ack_cnt = 0;
      run(60);
      chk("l4_ack_once", ack_cnt, 1);
      chk("l4_level", level, 4);
      chk("l4_cpu_en", cpu_en, 1);
      prev_p = ce_cpu_p;
      for (int i = 0; i < 8; i++) begin
         run(1);
         chk("l4_toggle", ce_cpu_p, !prev_p);
         chk("l4_alternate", ce_cpu_p ^ ce_cpu_n, 1);
         prev_p = ce_cpu_p;
      end

      // level 2 then step to 0
      level_req = 3'd2;
      run(60);
      chk("l2_level", level, 2);
      ack_cnt = 0; low_ticks = 0; level_req = 3'd0;
      run(200);
      chk("to0_low_ticks", low_ticks, 3);
      chk("to0_level", level, 0);
      chk("to0_ack", ack_cnt, 1);
      ce_sp = 1; ce_sn = 0; cycle();
      chk("follow_sp", ce_cpu_p, 1);
      chk("follow_sp_n", ce_cpu_n, 0);
      ce_sp = 0; ce_sn = 1; cycle();
      chk("follow_sn", ce_cpu_n, 1);

      // level 3 ram stall
      level_req = 3'd3;
      run(80);
      chk("l3_level", level, 3);
      ack_cnt = 0; saw_low = 0; ram_ready = 0;
      run(10);
      ram_ready = 1;
      run(20);
      chk("l3_stalled", saw_low, 1);
      chk("l3_no_ack", ack_cnt, 0);
      chk("l3_resumed", cpu_en, 1);

      // level 2 tape-qualified stall
      level_req = 3'd2;
      run(80);
      ram_ready = 0; tape_active = 0; saw_low = 0;
      run(40);
      chk("l2_no_stall", saw_low, 0);
      tape_active = 1;
      run(20);
      chk("l2_tape_stall", saw_low, 1);
      ram_ready = 1; tape_active = 0;
      run(20);

      // saturation and mid-HOLD change
      ack_cnt = 0; level_req = 3'd7;
      for (int i = 0; i < 100 && level != 3'd4; i++) run(1);
      chk("sat_level", level, 4);
      chk("sat_in_hold", cpu_en, 0);
      level_req = 3'd1;
      run(120);
      chk("midhold_ack", ack_cnt, 1);
      chk("midhold_level", level, 1);

      // reset during RESUME
      level_req = 3'd3; ram_ready = 0;
      run(60);
      chk("resume_level", level, 3);
      chk("resume_en", cpu_en, 0);
      reset_n = 0; level_req = 3'd0;
      #1;
      reset_literals("mid");
      model_reset();
      ack_cnt = 0;
      run(3);
      reset_n = 1; ram_ready = 1;
      run(40);
      chk("rst_no_ack", ack_cnt, 0);
      chk("rst_level", level, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 40) == 0) level_req = 3'($urandom_range(0, 7));
         ram_ready = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 30) == 0) tape_active = ~tape_active;
         ce_sp = ($urandom_range(0, 3) == 0);
         ce_sn = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 799) == 0) begin
            reset_n = 0;
            model_reset();
         end else begin
            reset_n = 1;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
